window_gen_3x3: RTL and testbench

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/win_pkg.sv | 38 +++
 rtl/line_buffer.sv | 43 ++++
 rtl/window_gen_3x3.sv | 202 ++++++++++++++++++++
 tb/tb_window_gen_3x3.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// +--------------------------------------------------------------------------+
// | win_pkg : shared constants, window field offsets and FSM state encoding   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package win_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 108;

    localparam int OFF_ORIG  = 96;
    localparam int OFF_LEFT  = 84;
    localparam int OFF_RIGHT = 72;
    localparam int OFF_UP    = 60;
    localparam int OFF_DOWN  = 48;
    localparam int OFF_UL    = 36;
    localparam int OFF_UR    = 24;
    localparam int OFF_DL    = 12;
    localparam int OFF_DR    = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // One vertical slice of the window: pixels from three consecutive rows.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// +--------------------------------------------------------------------------+
// | line_buffer : DEPTH-entry circular delay line, one write and one read     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module line_buffer #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    // The slot about to be overwritten holds the sample written DEPTH writes ago.
    assign rd_data_o = mem_q[ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (we_i) begin
            ptr_q <= (ptr_q == C_PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[ptr_q] <= wr_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_gen_3x3.sv
// +--------------------------------------------------------------------------+
// | window_gen_3x3 : raster RGB444 stream to 3x3 neighbourhood windows        |
// | Option: WINDOW_BORDER_REPLICATE_EN (clamp borders instead of zero fill)   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module window_gen_3x3
    import win_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIN_W-1:0] color_data,
    output logic             window_valid
);

`ifdef WINDOW_BORDER_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int K_W   = $clog2(N_PIX + IMG_W + 1);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [K_W-1:0]   C_K_FILL_END  = K_W'(IMG_W + 1);
    localparam logic [K_W-1:0]   C_K_LAST_IN   = K_W'(N_PIX - 1);
    localparam logic [K_W-1:0]   C_K_LAST_PUSH = K_W'(N_PIX + IMG_W);
    localparam logic [COL_W-1:0] C_COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST    = ROW_W'(IMG_H - 1);

    state_e           state_q;
    logic [K_W-1:0]   k_q;
    logic [COL_W-1:0] cen_col_q;
    logic [ROW_W-1:0] cen_row_q;
    col_t             col0_q;
    col_t             col1_q;
    logic [WIN_W-1:0] color_data_q;
    logic             window_valid_q;

    logic             accept;
    logic             sof_acc;
    logic             push;
    logic             emit;
    logic [PIX_W-1:0] bot_pix;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    col_t             col_new;
    logic [WIN_W-1:0] window_d;

    assign in_ready = ~reset & (state_q != DRAIN);
    assign accept   = in_valid & in_ready;
    assign sof_acc  = accept & in_sof;

    // DRAIN keeps the pipeline moving with dummy pixels so the last rows
    // shift out of the line buffers; their bottom row is always masked.
    assign push    = (accept & ((state_q != IDLE) | in_sof)) | (state_q == DRAIN);
    assign emit    = push & ~sof_acc & (k_q >= C_K_FILL_END);
    assign bot_pix = (state_q == DRAIN) ? '0 : in_pixel;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
        .clk       (clk),
        .reset     (reset),
        .we_i      (push),
        .wr_data_i (bot_pix),
        .rd_data_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
        .clk       (clk),
        .reset     (reset),
        .we_i      (push),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    assign col_new = '{top: lb1_rd, mid: lb0_rd, bot: bot_pix};

    function automatic col_t fix_rows(input col_t c, input logic first_row, input logic last_row);
        col_t r;
        r = c;
        if (first_row) r.top = REPLICATE ? c.mid : '0;
        if (last_row)  r.bot = REPLICATE ? c.mid : '0;
        return r;
    endfunction

    // Centre sits in col1; col0 is the left neighbour, col_new the right one.
    always_comb begin
        col_t cl;
        col_t cc;
        col_t cr;
        logic first_row;
        logic last_row;
        window_d  = '0;
        first_row = (cen_row_q == '0);
        last_row  = (cen_row_q == C_ROW_LAST);
        cl = (cen_col_q == '0)        ? (REPLICATE ? col1_q : '0) : col0_q;
        cr = (cen_col_q == C_COL_LAST) ? (REPLICATE ? col1_q : '0) : col_new;
        cl = fix_rows(cl, first_row, last_row);
        cc = fix_rows(col1_q, first_row, last_row);
        cr = fix_rows(cr, first_row, last_row);
        window_d[OFF_ORIG  +: PIX_W] = cc.mid;
        window_d[OFF_LEFT  +: PIX_W] = cl.mid;
        window_d[OFF_RIGHT +: PIX_W] = cr.mid;
        window_d[OFF_UP    +: PIX_W] = cc.top;
        window_d[OFF_DOWN  +: PIX_W] = cc.bot;
        window_d[OFF_UL    +: PIX_W] = cl.top;
        window_d[OFF_UR    +: PIX_W] = cr.top;
        window_d[OFF_DL    +: PIX_W] = cl.bot;
        window_d[OFF_DR    +: PIX_W] = cr.bot;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            col0_q <= col1_q;
            col1_q <= col_new;
        end
    end

    // k_q is the raster index of the next pixel pushed into the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cen_col_q <= '0;
            cen_row_q <= '0;
        end else begin
            if (emit) begin
                if (cen_col_q == C_COL_LAST) begin
                    cen_col_q <= '0;
                    cen_row_q <= cen_row_q + ROW_W'(1);
                end else begin
                    cen_col_q <= cen_col_q + COL_W'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (sof_acc) begin
                        state_q   <= FILL;
                        k_q       <= K_W'(1);
                        cen_col_q <= '0;
                        cen_row_q <= '0;
                    end
                end
                FILL, STREAM: begin
                    if (sof_acc) begin
                        state_q   <= FILL;
                        k_q       <= K_W'(1);
                        cen_col_q <= '0;
                        cen_row_q <= '0;
                    end else if (accept) begin
                        k_q <= k_q + K_W'(1);
                        if (state_q == FILL && k_q == C_K_FILL_END) begin
                            state_q <= STREAM;
                        end
                        if (state_q == STREAM && k_q == C_K_LAST_IN) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (k_q == C_K_LAST_PUSH) begin
                        state_q   <= IDLE;
                        k_q       <= '0;
                        cen_col_q <= '0;
                        cen_row_q <= '0;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_data_q   <= '0;
            window_valid_q <= 1'b0;
        end else begin
            window_valid_q <= emit;
            if (emit) begin
                color_data_q <= window_d;
            end
        end
    end

    assign color_data   = color_data_q;
    assign window_valid = window_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
// +--------------------------------------------------------------------------+
// | tb_window_gen_3x3 : scoreboard bench for window_gen_3x3 on a 4x3 image    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [11:0]  in_pixel = '0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic         in_ready;
    logic [107:0] color_data;
    logic         window_valid;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_ready     (in_ready),
        .color_data   (color_data),
        .window_valid (window_valid)
    );

    typedef struct {
        logic [107:0] data;
        int           due;
        int           centre;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           n_obs = 0;
    logic [107:0] obs [N];
    logic [107:0] c_centre;
    logic [107:0] c_corner;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference image: pixel value = raster index + 1, borders per build mode.
    function automatic logic [11:0] pix(input int r, input int c);
`ifdef WINDOW_BORDER_REPLICATE_EN
        int rr;
        int cc;
        rr = (r < 0) ? 0 : ((r > H - 1) ? H - 1 : r);
        cc = (c < 0) ? 0 : ((c > W - 1) ? W - 1 : c);
        return 12'(rr * W + cc + 1);
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 12'h000;
        return 12'(r * W + c + 1);
`endif
    endfunction

    function automatic logic [107:0] exp_win(input int j);
        int r;
        int c;
        r = j / W;
        c = j % W;
        return {pix(r, c), pix(r, c - 1), pix(r, c + 1), pix(r - 1, c), pix(r + 1, c),
                pix(r - 1, c - 1), pix(r - 1, c + 1), pix(r + 1, c - 1), pix(r + 1, c + 1)};
    endfunction

    always @(negedge clk) begin
        if (!reset && window_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_window", {127'd0, window_valid}, 128'd0);
            end else begin
                e = sbq.pop_front();
                check("window_data", color_data, e.data);
                check("window_cycle", cyc, e.due);
                obs[e.centre] = color_data;
                n_obs++;
            end
        end
    end

    task automatic drive(input logic [11:0] p, input logic v, input logic s);
        @(negedge clk);
        in_pixel = p;
        in_valid = v;
        in_sof   = s;
    endtask

    task automatic feed(input int upto, input int gap_at);
        for (int k = 0; k < upto; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < 3; g++) drive(12'hABC, 1'b0, 1'b0);
            end
            drive(12'(k + 1), 1'b1, (k == 0));
            check("in_ready_stream", {127'd0, in_ready}, 128'd1);
            if (k >= W + 1) sbq.push_back('{exp_win(k - W - 1), cyc + 1, k - W - 1});
        end
        if (upto == N) begin
            for (int i = 0; i <= W; i++) sbq.push_back('{exp_win(N - W - 1 + i), cyc + 2 + i, N - W - 1 + i});
        end
    endtask

    task automatic finish_frame();
        for (int i = 0; i < W + 1; i++) begin
            drive(12'h000, 1'b0, 1'b0);
            check("in_ready_drain", {127'd0, in_ready}, 128'd0);
        end
        drive(12'h000, 1'b0, 1'b0);
        check("in_ready_idle", {127'd0, in_ready}, 128'd1);
        drive(12'h000, 1'b0, 1'b0);
    endtask

    initial begin
        c_centre = {12'd6, 12'd5, 12'd7, 12'd2, 12'd10, 12'd1, 12'd3, 12'd9, 12'd11};
`ifdef WINDOW_BORDER_REPLICATE_EN
        c_corner = {12'd1, 12'd1, 12'd2, 12'd1, 12'd5, 12'd1, 12'd2, 12'd5, 12'd6};
`else
        c_corner = {12'd1, 12'd0, 12'd2, 12'd0, 12'd5, 12'd0, 12'd0, 12'd0, 12'd6};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_window_valid", {127'd0, window_valid}, 128'd0);
        check("rst_color_data", color_data, 128'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", {127'd0, in_ready}, 128'd1);

        // Pixels without sof in IDLE are discarded
        for (int i = 0; i < 3; i++) drive(12'(100 + i), 1'b1, 1'b0);

        // Full frame, no gaps
        n_obs = 0;
        feed(N, -1);
        finish_frame();
        check("frame1_count", n_obs, N);
        check("frame1_centre", obs[5], c_centre);
        check("frame1_corner", obs[0], c_corner);

        // Input stall of 3 cycles mid-frame
        n_obs = 0;
        feed(N, 7);
        finish_frame();
        check("stall_count", n_obs, N);
        check("stall_centre", obs[5], c_centre);

        // sof re-asserted at index 6 aborts the frame
        n_obs = 0;
        feed(6, -1);
        feed(N, -1);
        finish_frame();
        check("abort_count", n_obs, N + 1);
        check("abort_centre", obs[5], c_centre);
        check("abort_corner", obs[0], c_corner);

        // Reset during DRAIN
        feed(N, -1);
        drive(12'h000, 1'b0, 1'b0);
        drive(12'h000, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("drain_rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("drain_rst_window_valid", {127'd0, window_valid}, 128'd0);
        check("drain_rst_color_data", color_data, 128'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 8; i++) drive(12'(200 + i), 1'b1, 1'b0);
        drive(12'h000, 1'b0, 1'b0);
        drive(12'h000, 1'b0, 1'b0);

        // Recovery frame after reset
        n_obs = 0;
        feed(N, -1);
        finish_frame();
        check("recover_count", n_obs, N);
        check("recover_centre", obs[5], c_centre);
        check("scoreboard_empty", sbq.size(), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
